// File: rtl/eip_sequencer_if.sv
// Instruction-pointer sequencer bus.
// master: retire request (step, num_of_ope, mode, target) and clear_fault.
// slave : sequencer state (eip, depth, stack_full, stack_empty, fault, fault_code).
interface eip_sequencer_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned LEN_WIDTH   = 4
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                 step;
    logic [LEN_WIDTH-1:0] num_of_ope;
    logic [2:0]           mode;
    logic [WIDTH-1:0]     target;
    logic                 clear_fault;

    logic [WIDTH-1:0]     eip;
    logic [DEPTH_W-1:0]   depth;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 fault;
    logic [1:0]           fault_code;

    modport master (
        output step, num_of_ope, mode, target, clear_fault,
        input  eip, depth, stack_full, stack_empty, fault, fault_code
    );

    modport slave (
        input  step, num_of_ope, mode, target, clear_fault,
        output eip, depth, stack_full, stack_empty, fault, fault_code
    );
endinterface

// File: rtl/eip_sequencer.sv
// Instruction-pointer sequencer with a return stack and a sticky fault.
// Ports: clock, reset (async active-low), bus (eip_sequencer_if.slave).
// One retiring instruction per step cycle: SEQ, JMP_ABS, JMP_REL, CALL, RET.
// Overflow, underflow and reserved modes halt the sequencer until clear_fault.
module eip_sequencer #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000000a),
    parameter int unsigned     STACK_DEPTH = 4,
    parameter int unsigned     LEN_WIDTH   = 4
) (
    input logic           clock,
    input logic           reset,
    eip_sequencer_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS   = 1 << PTR_W;

    localparam logic [2:0] MODE_SEQ     = 3'd0;
    localparam logic [2:0] MODE_JMP_ABS = 3'd1;
    localparam logic [2:0] MODE_JMP_REL = 3'd2;
    localparam logic [2:0] MODE_CALL    = 3'd3;
    localparam logic [2:0] MODE_RET     = 3'd4;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_ILLEGAL   = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   eip_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [1:0]         fault_code_q;
    logic [WIDTH-1:0]   stack_mem [SLOTS];

    logic [WIDTH-1:0]   seq_next;
    logic               exec;
    logic               has_room;
    logic               has_entry;
    logic [PTR_W-1:0]   push_ptr;
    logic [PTR_W-1:0]   pop_ptr;

    // Fall-through address; zero-extended length, wraps modulo 2^WIDTH.
    assign seq_next  = eip_q + WIDTH'(bus.num_of_ope);
    // clear_fault takes priority over a step on the same edge.
    assign exec      = bus.step && (state_q == ST_RUN) && !bus.clear_fault;
    assign has_room  = depth_q < DEPTH_W'(STACK_DEPTH);
    assign has_entry = depth_q != '0;
    assign push_ptr  = PTR_W'(depth_q);
    assign pop_ptr   = PTR_W'(depth_q - DEPTH_W'(1));

    // Sequencer state and RUN/HALT control.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            eip_q        <= RESET_ADDR;
            depth_q      <= '0;
            fault_code_q <= FC_NONE;
        end else if (bus.clear_fault) begin
            state_q      <= ST_RUN;
            fault_code_q <= FC_NONE;
        end else if (exec) begin
            case (bus.mode)
                MODE_SEQ:     eip_q <= seq_next;
                MODE_JMP_ABS: eip_q <= bus.target;
                MODE_JMP_REL: eip_q <= seq_next + bus.target;
                MODE_CALL: begin
                    if (has_room) begin
                        eip_q   <= bus.target;
                        depth_q <= depth_q + DEPTH_W'(1);
                    end else begin
                        state_q      <= ST_HALT;
                        fault_code_q <= FC_OVERFLOW;
                    end
                end
                MODE_RET: begin
                    if (has_entry) begin
                        eip_q   <= stack_mem[pop_ptr];
                        depth_q <= depth_q - DEPTH_W'(1);
                    end else begin
                        state_q      <= ST_HALT;
                        fault_code_q <= FC_UNDERFLOW;
                    end
                end
                default: begin
                    state_q      <= ST_HALT;
                    fault_code_q <= FC_ILLEGAL;
                end
            endcase
        end
    end

    // Return-stack storage; contents need no reset since depth gates every read.
    always_ff @(posedge clock) begin
        if (exec && (bus.mode == MODE_CALL) && has_room) begin
            stack_mem[push_ptr] <= seq_next;
        end
    end

    assign bus.eip         = eip_q;
    assign bus.depth       = depth_q;
    assign bus.fault       = (state_q == ST_HALT);
    assign bus.fault_code  = fault_code_q;
    assign bus.stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign bus.stack_empty = (depth_q == '0);
endmodule

// File: tb/tb_eip_sequencer.sv
// Directed self-checking bench for eip_sequencer (WIDTH=32, STACK_DEPTH=4).
module tb_eip_sequencer;
    localparam int unsigned WIDTH       = 32;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned LEN_WIDTH   = 4;

    localparam logic [2:0] M_SEQ = 3'd0;
    localparam logic [2:0] M_ABS = 3'd1;
    localparam logic [2:0] M_REL = 3'd2;
    localparam logic [2:0] M_CALL = 3'd3;
    localparam logic [2:0] M_RET = 3'd4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    eip_sequencer_if #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    eip_sequencer #(
        .WIDTH(WIDTH), .RESET_ADDR(32'h0000000a),
        .STACK_DEPTH(STACK_DEPTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply one retire request for a single edge, then idle the inputs.
    task automatic op(input logic [2:0] m, input logic [3:0] n, input logic [31:0] t);
        bus.step = 1'b1; bus.mode = m; bus.num_of_ope = n; bus.target = t;
        tick();
        bus.step = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e, input logic [31:0] d,
                               input logic [31:0] f, input logic [31:0] fc);
        check({tag, ".eip"},   bus.eip, e);
        check({tag, ".depth"}, 32'(bus.depth), d);
        check({tag, ".fault"}, 32'(bus.fault), f);
        check({tag, ".code"},  32'(bus.fault_code), fc);
    endtask

    initial begin
        bus.step = 1'b0; bus.mode = M_SEQ; bus.num_of_ope = '0;
        bus.target = '0; bus.clear_fault = 1'b0;

        // Reset held across edges, released mid-cycle.
        tick(); tick();
        check_state("reset", 32'h0a, 0, 0, 0);
        check("reset.empty", 32'(bus.stack_empty), 1);
        check("reset.full",  32'(bus.stack_full), 0);
        #3 reset = 1'b1;

        // Sequential steps.
        op(M_SEQ, 4'd1, '0); check("seq1", bus.eip, 32'h0b);
        op(M_SEQ, 4'd2, '0); check("seq2", bus.eip, 32'h0d);
        op(M_SEQ, 4'd4, '0); check("seq4", bus.eip, 32'h11);
        op(M_SEQ, 4'd5, '0); check("seq5", bus.eip, 32'h16);

        // Wrap-around and zero length.
        op(M_ABS, 4'd3, 32'hfffffffe); check("abs", bus.eip, 32'hfffffffe);
        op(M_SEQ, 4'd3, '0);           check("wrap", bus.eip, 32'h00000001);
        op(M_SEQ, 4'd0, '0);           check_state("seq0", 32'h1, 0, 0, 0);

        // Relative jump with negative offset.
        op(M_ABS, 4'd1, 32'h100);      check("abs100", bus.eip, 32'h100);
        op(M_REL, 4'd2, 32'hfffffff0); check("rel", bus.eip, 32'hf2);

        // step low: nothing changes regardless of mode.
        bus.step = 1'b0; bus.mode = M_ABS; bus.target = 32'h555; tick();
        check("nostep", bus.eip, 32'hf2);

        // Fill the return stack.
        op(M_ABS, 4'd1, 32'h0a);
        op(M_CALL, 4'd5, 32'h100); check("call1", bus.eip, 32'h100);
        op(M_CALL, 4'd5, 32'h200);
        op(M_CALL, 4'd5, 32'h300);
        op(M_CALL, 4'd5, 32'h400);
        check_state("call4", 32'h400, 4, 0, 0);
        check("call4.full",  32'(bus.stack_full), 1);
        check("call4.empty", 32'(bus.stack_empty), 0);

        // Overflow, then requests while halted keep the first code.
        op(M_CALL, 4'd5, 32'h500);  check_state("ovf", 32'h400, 4, 1, 1);
        op(M_RET, 4'd1, '0);        check_state("halt.ret", 32'h400, 4, 1, 1);
        op(3'd7, 4'd1, '0);         check_state("halt.ill", 32'h400, 4, 1, 1);

        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        check_state("clr1", 32'h400, 4, 0, 0);

        // Unwind.
        op(M_RET, 4'd1, '0); check_state("ret1", 32'h305, 3, 0, 0);
        op(M_RET, 4'd1, '0); check_state("ret2", 32'h205, 2, 0, 0);
        op(M_RET, 4'd1, '0); check_state("ret3", 32'h105, 1, 0, 0);
        op(M_RET, 4'd1, '0); check_state("ret4", 32'h0f, 0, 0, 0);
        check("ret4.empty", 32'(bus.stack_empty), 1);

        // Underflow; steps ignored while halted.
        op(M_RET, 4'd1, '0); check_state("udf", 32'h0f, 0, 1, 2);
        op(M_SEQ, 4'd1, '0); check_state("udf.seq", 32'h0f, 0, 1, 2);

        // clear_fault and step on the same edge: step dropped.
        bus.clear_fault = 1'b1;
        op(M_SEQ, 4'd4, '0);
        bus.clear_fault = 1'b0;
        check_state("clr2", 32'h0f, 0, 0, 0);
        op(M_SEQ, 4'd4, '0); check("after.clr", bus.eip, 32'h13);

        // Reserved mode.
        op(3'd6, 4'd2, 32'h77); check_state("ill", 32'h13, 0, 1, 3);
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        bus.step = 1'b0; bus.mode = 3'd7; tick();
        check_state("ill.nostep", 32'h13, 0, 0, 0);

        // Async reset pulse between edges during a CALL sequence.
        op(M_CALL, 4'd1, 32'h100); check_state("pre.rst", 32'h100, 1, 0, 0);
        bus.step = 1'b1; bus.mode = M_CALL; bus.num_of_ope = 4'd1; bus.target = 32'h200;
        #2 reset = 1'b0;
        #1 check_state("async.rst", 32'h0a, 0, 0, 0);
        bus.mode = M_RET;
        #1 reset = 1'b1;
        tick(); bus.step = 1'b0;
        check_state("rst.ret", 32'h0a, 0, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
